// File: rtl/icg_enable_ctrl.sv
// Enable generator for a TLATNCAX2 clock gate: drops E after a run of idle cycles and
// restores it through a fixed-length wake sequence that ends in a one-cycle wake_ack.
module icg_enable_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             busy,
  input  logic             sleep_en,
  input  logic             wake_req,
  output logic             E,
  output logic             wake_ack,
  output logic             gated,
  output logic [CNT_W-1:0] idle_cnt
);

  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WakeLast = CNT_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StCount = 2'd1,
    StGated = 2'd2,
    StWake  = 2'd3
  } state_e;

  state_e state;
  logic   idle;

  assign idle = sleep_en & ~busy & ~wake_req;

  // All outputs are registered so E only moves right after a CK rising edge.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state    <= StRun;
      E        <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
      idle_cnt <= '0;
    end else begin
      wake_ack <= 1'b0;
      unique case (state)
        StRun: begin
          if (idle) begin
            state    <= StCount;
            idle_cnt <= CNT_W'(1);
          end
        end
        StCount: begin
          // A non-idle sample wins over the terminal count.
          if (!idle) begin
            state    <= StRun;
            idle_cnt <= '0;
          end else if (idle_cnt == IdleLast) begin
            state    <= StGated;
            idle_cnt <= '0;
            E        <= 1'b0;
            gated    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        StGated: begin
          if (wake_req || busy || !sleep_en) begin
            state    <= StWake;
            idle_cnt <= '0;
            E        <= 1'b1;
            gated    <= 1'b0;
          end
        end
        StWake: begin
          // Inputs are ignored until the wake sequence completes.
          if (idle_cnt == WakeLast) begin
            state    <= StRun;
            idle_cnt <= '0;
            wake_ack <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= StRun;
          idle_cnt <= '0;
          E        <= 1'b1;
          gated    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Directed bench for icg_enable_ctrl: default parameters on dut_a and the minimal
// IDLE_CYCLES=2 / WAKE_CYCLES=1 configuration on dut_b.
module tb_icg_enable_ctrl;

  logic       CK = 1'b0;
  logic       rn_a, busy_a, sleep_a, wreq_a;
  logic       e_a, ack_a, gated_a;
  logic [4:0] cnt_a;
  logic       rn_b, busy_b, sleep_b, wreq_b;
  logic       e_b, ack_b, gated_b;
  logic [1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  icg_enable_ctrl dut_a (
    .CK       (CK),
    .RN       (rn_a),
    .busy     (busy_a),
    .sleep_en (sleep_a),
    .wake_req (wreq_a),
    .E        (e_a),
    .wake_ack (ack_a),
    .gated    (gated_a),
    .idle_cnt (cnt_a)
  );

  icg_enable_ctrl #(
    .IDLE_CYCLES (2),
    .WAKE_CYCLES (1),
    .CNT_W       (2)
  ) dut_b (
    .CK       (CK),
    .RN       (rn_b),
    .busy     (busy_b),
    .sleep_en (sleep_b),
    .wake_req (wreq_b),
    .E        (e_b),
    .wake_ack (ack_b),
    .gated    (gated_b),
    .idle_cnt (cnt_b)
  );

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic st_a(input string tag, input int e, input int g, input int a, input int c);
    chk({tag, ".E"}, int'(e_a), e);
    chk({tag, ".gated"}, int'(gated_a), g);
    chk({tag, ".wake_ack"}, int'(ack_a), a);
    chk({tag, ".idle_cnt"}, int'(cnt_a), c);
  endtask

  task automatic st_b(input string tag, input int e, input int g, input int a, input int c);
    chk({tag, ".E"}, int'(e_b), e);
    chk({tag, ".gated"}, int'(gated_b), g);
    chk({tag, ".wake_ack"}, int'(ack_b), a);
    chk({tag, ".idle_cnt"}, int'(cnt_b), c);
  endtask

  initial begin
    rn_a = 1'b0; busy_a = 1'b0; sleep_a = 1'b0; wreq_a = 1'b0;
    rn_b = 1'b0; busy_b = 1'b0; sleep_b = 1'b0; wreq_b = 1'b0;
    step();
    step();
    st_a("reset", 1, 0, 0, 0);

    // First gating run: 16 idle samples.
    rn_a = 1'b1; sleep_a = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      st_a($sformatf("idle%0d", i), 1, 0, 0, i);
    end
    step();
    st_a("gate", 0, 1, 0, 0);
    step();
    st_a("gated_hold", 0, 1, 0, 0);

    // One-cycle wake_req pulse.
    wreq_a = 1'b1;
    step();
    wreq_a = 1'b0;
    st_a("wake0", 1, 0, 0, 0);
    step();
    st_a("wake1", 1, 0, 0, 1);
    step();
    st_a("ack", 1, 0, 1, 0);
    step();
    st_a("post_ack", 1, 0, 0, 1);

    // Idle run broken by busy after 10 samples.
    for (int i = 2; i <= 10; i++) step();
    st_a("idle10", 1, 0, 0, 10);
    busy_a = 1'b1;
    step();
    busy_a = 1'b0;
    st_a("busy_break", 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("rerun%0d.E", i), int'(e_a), 1);
      chk($sformatf("rerun%0d.cnt", i), int'(cnt_a), i);
    end
    step();
    st_a("regate", 0, 1, 0, 0);

    // Wake via sleep_en=0, which then holds the clock on.
    sleep_a = 1'b0;
    step();
    st_a("sw_wake0", 1, 0, 0, 0);
    step();
    st_a("sw_wake1", 1, 0, 0, 1);
    step();
    st_a("sw_ack", 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      st_a($sformatf("sleep_off%0d", i), 1, 0, 0, 0);
    end

    // wake_req held high never lets the count start.
    sleep_a = 1'b1; wreq_a = 1'b1;
    for (int i = 0; i < 20; i++) step();
    st_a("wreq_held", 1, 0, 0, 0);
    wreq_a = 1'b0;

    // Reset during WAKE with cnt=1: no ack afterwards.
    for (int i = 0; i < 16; i++) step();
    st_a("gate3", 0, 1, 0, 0);
    busy_a = 1'b1;
    step();
    busy_a = 1'b0;
    step();
    st_a("wake_cnt1", 1, 0, 0, 1);
    rn_a = 1'b0;
    step();
    st_a("rst_in_wake", 1, 0, 0, 0);
    rn_a = 1'b1;
    step();
    st_a("after_rst_wake", 1, 0, 0, 1);

    // Reset during GATED.
    for (int i = 1; i < 16; i++) step();
    st_a("gate4", 0, 1, 0, 0);
    rn_a = 1'b0;
    step();
    st_a("rst_in_gated", 1, 0, 0, 0);
    rn_a = 1'b1; sleep_a = 1'b0;
    step();
    st_a("after_rst_gated", 1, 0, 0, 0);
    step();
    chk("after_rst_gated2.wake_ack", int'(ack_a), 0);

    // Minimal configuration: IDLE_CYCLES=2, WAKE_CYCLES=1.
    st_b("b_reset", 1, 0, 0, 0);
    rn_b = 1'b1; sleep_b = 1'b1;
    step();
    st_b("b_idle1", 1, 0, 0, 1);
    step();
    st_b("b_gate", 0, 1, 0, 0);
    wreq_b = 1'b1;
    step();
    wreq_b = 1'b0;
    st_b("b_wake", 1, 0, 0, 0);
    step();
    st_b("b_ack", 1, 0, 1, 0);
    step();
    st_b("b_idle1b", 1, 0, 0, 1);
    busy_b = 1'b1;
    step();
    busy_b = 1'b0;
    st_b("b_busy_terminal", 1, 0, 0, 0);
    step();
    st_b("b_idle1c", 1, 0, 0, 1);
    step();
    st_b("b_gate2", 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
